// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I OP/OP-IMM/LUI/AUIPC decode stage with valid/ready handshake
module id_stage #(
    parameter int XLEN      = 32,
    parameter int OH_W      = 5,
    parameter int ILL_CNT_W = 16,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      ins_addr2id,
    input  logic [31:0]          ins,
    input  logic                 flush,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic                 wb_wen,
    input  logic [4:0]           wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      op1,
    output logic [XLEN-1:0]      op2,
    output logic [31:0]          ins2ex,
    output logic [XLEN-1:0]      ins_addr,
    output logic [4:0]           rd_addr,
    output logic                 rd_wen,
    output logic [OH_W-1:0]      oh,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_field;

    assign opcode   = ins[6:0];
    assign f3       = ins[14:12];
    assign f7       = ins[31:25];
    assign rd_field = ins[11:7];

    logic [4:0] dec_idx;
    logic       dec_legal;
    logic       is_opimm;
    logic       is_op;
    logic       is_lui;
    logic       is_auipc;
    logic       is_shimm;

    // Map opcode/funct3/funct7 to the op index; index 0 means not decodable.
    always_comb begin
        dec_idx  = 5'd0;
        is_opimm = (opcode == OPC_OPIMM);
        is_op    = (opcode == OPC_OP);
        is_lui   = (opcode == OPC_LUI);
        is_auipc = (opcode == OPC_AUIPC);
        is_shimm = is_opimm && ((f3 == 3'b001) || (f3 == 3'b101));
        if (is_opimm) begin
            case (f3)
                3'b000:  dec_idx = 5'd1;
                3'b010:  dec_idx = 5'd4;
                3'b011:  dec_idx = 5'd5;
                3'b100:  dec_idx = 5'd6;
                3'b110:  dec_idx = 5'd7;
                3'b111:  dec_idx = 5'd8;
                3'b001:  dec_idx = (f7 == F7_ZERO) ? 5'd9 : 5'd0;
                3'b101:  dec_idx = (f7 == F7_ZERO) ? 5'd10 :
                                   (f7 == F7_ALT)  ? 5'd11 : 5'd0;
                default: dec_idx = 5'd0;
            endcase
        end else if (is_op) begin
            if (f7 == F7_ZERO) begin
                case (f3)
                    3'b000:  dec_idx = 5'd2;
                    3'b001:  dec_idx = 5'd12;
                    3'b010:  dec_idx = 5'd13;
                    3'b011:  dec_idx = 5'd14;
                    3'b100:  dec_idx = 5'd15;
                    3'b101:  dec_idx = 5'd16;
                    3'b110:  dec_idx = 5'd18;
                    default: dec_idx = 5'd19;
                endcase
            end else if (f7 == F7_ALT) begin
                if (f3 == 3'b000) begin
                    dec_idx = 5'd3;
                end else if (f3 == 3'b101) begin
                    dec_idx = 5'd17;
                end
            end
        end else if (is_lui) begin
            dec_idx = 5'd20;
        end else if (is_auipc) begin
            dec_idx = 5'd21;
        end
    end

    assign dec_legal = (dec_idx != 5'd0);

    // Regfile addresses are driven straight from the incoming word, independent of handshake.
    assign rs1_addr = (dec_legal && (is_op || is_opimm)) ? ins[19:15] : 5'd0;
    assign rs2_addr = (dec_legal && is_op) ? ins[24:20] : 5'd0;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_u;

    // Writeback bypass and immediate formation.
    always_comb begin
        rs1_val = rs1_data;
        rs2_val = rs2_data;
        if ((BYPASS != 0) && wb_wen && (wb_addr != 5'd0)) begin
            if (wb_addr == rs1_addr) rs1_val = wb_data;
            if (wb_addr == rs2_addr) rs2_val = wb_data;
        end
        imm_i        = {XLEN{ins[31]}};
        imm_i[11:0]  = ins[31:20];
        imm_sh       = '0;
        imm_sh[4:0]  = ins[24:20];
        imm_u        = {XLEN{ins[31]}};
        imm_u[31:0]  = {ins[31:12], 12'b0};
    end

    logic [XLEN-1:0] op1_d;
    logic [XLEN-1:0] op2_d;
    logic [4:0]      rd_addr_d;
    logic            rd_wen_d;

    // Operand selection; illegal decodes zero the operands and destination.
    always_comb begin
        op1_d     = '0;
        op2_d     = '0;
        rd_wen_d  = dec_legal && (rd_field != 5'd0);
        rd_addr_d = rd_wen_d ? rd_field : 5'd0;
        if (dec_legal) begin
            if (is_opimm) begin
                op1_d = rs1_val;
                op2_d = is_shimm ? imm_sh : imm_i;
            end else if (is_op) begin
                op1_d = rs1_val;
                op2_d = rs2_val;
            end else if (is_lui) begin
                op2_d = imm_u;
            end else begin
                op1_d = ins_addr2id;
                op2_d = imm_u;
            end
        end
    end

    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [XLEN-1:0]      op1_q;
    logic [XLEN-1:0]      op2_q;
    logic [31:0]          ins2ex_q;
    logic [XLEN-1:0]      ins_addr_q;
    logic [4:0]           rd_addr_q;
    logic                 rd_wen_q;
    logic [OH_W-1:0]      oh_q;
    logic                 illegal_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q;
    logic [ILL_CNT_W-1:0] ill_cnt_d;
    logic                 load;

    assign in_ready = !out_valid_q || out_ready || flush;
    assign load     = in_valid && in_ready && !flush;

    // Handshake next state: flush wins, a stall holds, otherwise follow in_valid.
    always_comb begin
        out_valid_d = out_valid_q;
        ill_cnt_d   = ill_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_ready) begin
            out_valid_d = in_valid;
        end
        if (load && !dec_legal && !(&ill_cnt_q)) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    // ID/EX pipeline register; data only moves on an accepted, non-flushed beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            ins2ex_q    <= '0;
            ins_addr_q  <= '0;
            rd_addr_q   <= '0;
            rd_wen_q    <= 1'b0;
            oh_q        <= '0;
            illegal_q   <= 1'b0;
            ill_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ill_cnt_q   <= ill_cnt_d;
            if (load) begin
                op1_q      <= op1_d;
                op2_q      <= op2_d;
                ins2ex_q   <= ins;
                ins_addr_q <= ins_addr2id;
                rd_addr_q  <= rd_addr_d;
                rd_wen_q   <= rd_wen_d;
                oh_q       <= OH_W'(dec_idx);
                illegal_q  <= !dec_legal;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign ins2ex    = ins2ex_q;
    assign ins_addr  = ins_addr_q;
    assign rd_addr   = rd_addr_q;
    assign rd_wen    = rd_wen_q;
    assign oh        = oh_q;
    assign illegal   = illegal_q;
    assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready, wb_wen;
    logic [31:0] ins, ins_addr2id, wb_data, rs1_data, rs2_data;
    logic [4:0]  wb_addr;
    logic        in_ready, out_valid, rd_wen, illegal;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, oh;
    logic [31:0] op1, op2, ins2ex, ins_addr;
    logic [15:0] ill_cnt;

    logic        s_in_ready, s_out_valid, s_rd_wen, s_illegal;
    logic [4:0]  s_rs1_addr, s_rs2_addr, s_rd_addr, s_oh;
    logic [31:0] s_op1, s_op2, s_ins2ex, s_ins_addr;
    logic [1:0]  s_ill_cnt;

    always #5 clk = ~clk;

    id_stage u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ins_addr2id(ins_addr2id), .ins(ins), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
        .ins2ex(ins2ex), .ins_addr(ins_addr), .rd_addr(rd_addr), .rd_wen(rd_wen),
        .oh(oh), .illegal(illegal), .ill_cnt(ill_cnt)
    );

    id_stage #(.ILL_CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .ins_addr2id(ins_addr2id), .ins(ins), .flush(flush),
        .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .op1(s_op1), .op2(s_op2),
        .ins2ex(s_ins2ex), .ins_addr(s_ins_addr), .rd_addr(s_rd_addr), .rd_wen(s_rd_wen),
        .oh(s_oh), .illegal(s_illegal), .ill_cnt(s_ill_cnt)
    );

    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    localparam int K_IARITH = 0;
    localparam int K_ISHIFT = 1;
    localparam int K_R      = 2;
    localparam int K_LUI    = 3;
    localparam int K_AUIPC  = 4;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         use_f7;
        int         kind;
        int         idx;
    } desc_t;

    desc_t descs [21];

    typedef struct {
        logic [4:0]  oh;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
    } dec_t;

    function automatic logic [31:0] rv(input logic [4:0] a);
        if (wb_wen && wb_addr != 5'd0 && wb_addr == a) return wb_data;
        return regs[a];
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        dec_t r;
        int k;
        k = -1;
        r = '{default: '0};
        for (int i = 0; i < 21; i++) begin
            if (w[6:0] == descs[i].opc &&
                (descs[i].kind >= K_LUI || w[14:12] == descs[i].f3) &&
                (!descs[i].use_f7 || w[31:25] == descs[i].f7))
                k = i;
        end
        if (k < 0) begin
            r.ill = 1'b1;
            return r;
        end
        r.oh = 5'(descs[k].idx);
        case (descs[k].kind)
            K_IARITH: begin r.ra1 = w[19:15]; r.op1 = rv(r.ra1); r.op2 = {{20{w[31]}}, w[31:20]}; end
            K_ISHIFT: begin r.ra1 = w[19:15]; r.op1 = rv(r.ra1); r.op2 = {27'd0, w[24:20]}; end
            K_R: begin
                r.ra1 = w[19:15]; r.ra2 = w[24:20];
                r.op1 = rv(r.ra1); r.op2 = rv(r.ra2);
            end
            K_LUI:   begin r.op1 = 32'd0; r.op2 = {w[31:12], 12'd0}; end
            default: begin r.op1 = pc;    r.op2 = {w[31:12], 12'd0}; end
        endcase
        r.wen = (w[11:7] != 5'd0);
        r.rd  = r.wen ? w[11:7] : 5'd0;
        return r;
    endfunction

    dec_t        m;
    logic        m_valid;
    logic [31:0] m_ins, m_pc;
    logic [15:0] m_cnt;
    logic [1:0]  m_sat;

    task automatic model_reset();
        m = '{default: '0};
        m_valid = 0; m_ins = 0; m_pc = 0; m_cnt = 0; m_sat = 0;
    endtask

    task automatic check_regs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("oh", {27'd0, oh}, {27'd0, m.oh});
        chk("op1", op1, m.op1);
        chk("op2", op2, m.op2);
        chk("rd_addr", {27'd0, rd_addr}, {27'd0, m.rd});
        chk("rd_wen", {31'd0, rd_wen}, {31'd0, m.wen});
        chk("illegal", {31'd0, illegal}, {31'd0, m.ill});
        chk("ins2ex", ins2ex, m_ins);
        chk("ins_addr", ins_addr, m_pc);
        chk("ill_cnt", {16'd0, ill_cnt}, {16'd0, m_cnt});
        chk("sat_ill_cnt", {30'd0, s_ill_cnt}, {30'd0, m_sat});
    endtask

    // Inputs are already set; check combinational outputs, clock once, check registers.
    task automatic tick();
        dec_t d;
        logic rdy, acc;
        #2;
        d   = ref_decode(ins, ins_addr2id);
        rdy = !m_valid || out_ready || flush;
        acc = in_valid && rdy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, d.ra1});
        chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, d.ra2});
        @(posedge clk);
        if (acc && !flush) begin
            m = d; m_ins = ins; m_pc = ins_addr2id;
            if (d.ill) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_sat != 2'd3) m_sat = m_sat + 2'd1;
            end
        end
        if (flush) m_valid = 1'b0;
        else if (rdy) m_valid = in_valid;
        #1;
        check_regs();
    endtask

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 3))
            0, 1: return 7'h00;
            2: return 7'h20;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0] rs1, rs2, rd;
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: return {12'($urandom), rs1, 3'($urandom), rd, 7'h13};
            1: return {pick_f7(), 5'($urandom), rs1, ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b101, rd, 7'h13};
            2: return {pick_f7(), rs2, rs1, 3'($urandom), rd, 7'h33};
            3: return {20'($urandom), rd, 7'h37};
            4: return {20'($urandom), rd, 7'h17};
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [4:0]  oh;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cbase;

        descs[0]  = '{7'h13, 3'b000, 7'h00, 0, K_IARITH, 1};
        descs[1]  = '{7'h13, 3'b010, 7'h00, 0, K_IARITH, 4};
        descs[2]  = '{7'h13, 3'b011, 7'h00, 0, K_IARITH, 5};
        descs[3]  = '{7'h13, 3'b100, 7'h00, 0, K_IARITH, 6};
        descs[4]  = '{7'h13, 3'b110, 7'h00, 0, K_IARITH, 7};
        descs[5]  = '{7'h13, 3'b111, 7'h00, 0, K_IARITH, 8};
        descs[6]  = '{7'h13, 3'b001, 7'h00, 1, K_ISHIFT, 9};
        descs[7]  = '{7'h13, 3'b101, 7'h00, 1, K_ISHIFT, 10};
        descs[8]  = '{7'h13, 3'b101, 7'h20, 1, K_ISHIFT, 11};
        descs[9]  = '{7'h33, 3'b000, 7'h00, 1, K_R, 2};
        descs[10] = '{7'h33, 3'b000, 7'h20, 1, K_R, 3};
        descs[11] = '{7'h33, 3'b001, 7'h00, 1, K_R, 12};
        descs[12] = '{7'h33, 3'b010, 7'h00, 1, K_R, 13};
        descs[13] = '{7'h33, 3'b011, 7'h00, 1, K_R, 14};
        descs[14] = '{7'h33, 3'b100, 7'h00, 1, K_R, 15};
        descs[15] = '{7'h33, 3'b101, 7'h00, 1, K_R, 16};
        descs[16] = '{7'h33, 3'b101, 7'h20, 1, K_R, 17};
        descs[17] = '{7'h33, 3'b110, 7'h00, 1, K_R, 18};
        descs[18] = '{7'h33, 3'b111, 7'h00, 1, K_R, 19};
        descs[19] = '{7'h37, 3'b000, 7'h00, 0, K_LUI, 20};
        descs[20] = '{7'h17, 3'b000, 7'h00, 0, K_AUIPC, 21};

        vecs[0]  = '{32'hFFD08293, 32'h0,   5'd1,  32'd10,  32'hFFFFFFFD, 5'd5,  1'b1, 1'b0};
        vecs[1]  = '{32'h402081B3, 32'h4,   5'd3,  32'd10,  32'd20,       5'd3,  1'b1, 1'b0};
        vecs[2]  = '{32'h41F0D213, 32'h8,   5'd11, 32'd10,  32'd31,       5'd4,  1'b1, 1'b0};
        vecs[3]  = '{32'h0000007F, 32'hC,   5'd0,  32'd0,   32'd0,        5'd0,  1'b0, 1'b1};
        vecs[4]  = '{32'h40309293, 32'h10,  5'd0,  32'd0,   32'd0,        5'd0,  1'b0, 1'b1};
        vecs[5]  = '{32'h00001037, 32'h14,  5'd20, 32'd0,   32'h1000,     5'd0,  1'b0, 1'b0};
        vecs[6]  = '{32'h00001417, 32'h100, 5'd21, 32'h100, 32'h1000,     5'd8,  1'b1, 1'b0};
        vecs[7]  = '{32'h800004B7, 32'h104, 5'd20, 32'd0,   32'h80000000, 5'd9,  1'b1, 1'b0};
        vecs[8]  = '{32'h00113513, 32'h108, 5'd5,  32'd20,  32'd1,        5'd10, 1'b1, 1'b0};
        vecs[9]  = '{32'h0020F5B3, 32'h10C, 5'd19, 32'd10,  32'd20,       5'd11, 1'b1, 1'b0};
        vecs[10] = '{32'h402091B3, 32'h110, 5'd0,  32'd0,   32'd0,        5'd0,  1'b0, 1'b1};
        vecs[11] = '{32'h00208033, 32'h114, 5'd2,  32'd10,  32'd20,       5'd0,  1'b0, 1'b0};

        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 10);

        rst_n = 0; in_valid = 0; flush = 0; out_ready = 0; wb_wen = 0;
        ins = 0; ins_addr2id = 0; wb_data = 0; wb_addr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check_regs();

        // Table vectors, back to back with out_ready high.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1; out_ready = 1; flush = 0; wb_wen = 0;
            ins = vecs[i].ins; ins_addr2id = vecs[i].pc;
            tick();
            chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("tbl%0d_oh", i), {27'd0, oh}, {27'd0, vecs[i].oh});
            chk($sformatf("tbl%0d_op1", i), op1, vecs[i].op1);
            chk($sformatf("tbl%0d_op2", i), op2, vecs[i].op2);
            chk($sformatf("tbl%0d_rd", i), {27'd0, rd_addr}, {27'd0, vecs[i].rd});
            chk($sformatf("tbl%0d_wen", i), {31'd0, rd_wen}, {31'd0, vecs[i].wen});
            chk($sformatf("tbl%0d_ill", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
        end
        chk("tbl_ill_cnt", {16'd0, ill_cnt}, 32'd3);

        // Bypass: add x6,x7,x7 with x7 being written back this cycle.
        ins = 32'h00738333; wb_wen = 1; wb_addr = 5'd7; wb_data = 32'h55;
        tick();
        chk("byp_op1", op1, 32'h55);
        chk("byp_op2", op2, 32'h55);
        wb_wen = 0;

        // Stall: sub accepted, then srai held off for 3 cycles.
        ins = 32'h402081B3; out_ready = 1;
        tick();
        ins = 32'h41F0D213; out_ready = 0;
        repeat (3) begin
            tick();
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_oh", {27'd0, oh}, 32'd3);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1;
        tick();
        chk("unstall_oh", {27'd0, oh}, 32'd11);
        chk("unstall_op2", op2, 32'd31);

        // Two illegals in a row, then a flushed illegal.
        cbase = m_cnt;
        ins = 32'h0000007F;
        tick();
        chk("ill1_cnt", {16'd0, ill_cnt}, {16'd0, cbase + 16'd1});
        ins = 32'h40309293;
        tick();
        chk("ill2_cnt", {16'd0, ill_cnt}, {16'd0, cbase + 16'd2});
        chk("ill2_oh", {27'd0, oh}, 32'd0);
        chk("ill2_wen", {31'd0, rd_wen}, 32'd0);
        chk("sat_cnt", {30'd0, s_ill_cnt}, 32'd3);
        ins = 32'h0000007F; flush = 1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_cnt", {16'd0, ill_cnt}, {16'd0, cbase + 16'd2});
        flush = 0;

        // Randomized traffic against the reference model.
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int n = 0; n < 500; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            wb_wen      = $urandom_range(0, 1) != 0;
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            ins         = rand_ins();
            ins_addr2id = $urandom & 32'hFFFFFFFC;
            tick();
        end

        // Asynchronous reset in the middle of a held beat.
        in_valid = 1; out_ready = 0; flush = 0; wb_wen = 0; ins = 32'hFFD08293;
        tick();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_oh", {27'd0, oh}, 32'd0);
        chk("arst_cnt", {16'd0, ill_cnt}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        check_regs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
